// File: rtl/wb_ram_arbiter.sv
// Two-master Wishbone arbiter in front of a single wb_ram slave port.
// Define WB_ARB_TIMEOUT_EN to build in the stalled-strobe watchdog.
module wb_ram_arbiter #(
  parameter int PRIO_FIXED = 0,
  parameter int TIMEOUT    = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_instr_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_instr_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t r_state, w_next;
  logic   r_last, w_last_next;
  logic   w_timeout;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      r_last  <= w_last_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_last_next = r_last;
    case (r_state)
      IDLE: begin
        // On a tie, round-robin hands the bus to whoever did not own it last.
        if (m0_cyc_i && m1_cyc_i)
          w_next = (PRIO_FIXED != 0 || r_last) ? OWN0 : OWN1;
        else if (m0_cyc_i)
          w_next = OWN0;
        else if (m1_cyc_i)
          w_next = OWN1;
      end
      OWN0: begin
        if (!m0_cyc_i) begin
          w_next      = IDLE;
          w_last_next = 1'b0;
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          w_next      = IDLE;
          w_last_next = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_instr_o = 1'b0;
    m0_ack_o  = 1'b0;
    m1_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_err_o  = 1'b0;
    case (r_state)
      OWN0: begin
        s_adr_o   = m0_adr_i;
        s_dat_o   = m0_dat_i;
        s_sel_o   = m0_sel_i;
        s_we_o    = m0_we_i;
        s_cyc_o   = m0_cyc_i;
        s_stb_o   = m0_stb_i & ~w_timeout;
        s_instr_o = m0_instr_i;
        m0_ack_o  = s_ack_i;
        m0_err_o  = w_timeout;
      end
      OWN1: begin
        s_adr_o   = m1_adr_i;
        s_dat_o   = m1_dat_i;
        s_sel_o   = m1_sel_i;
        s_we_o    = m1_we_i;
        s_cyc_o   = m1_cyc_i;
        s_stb_o   = m1_stb_i & ~w_timeout;
        m1_ack_o  = s_ack_i;
        m1_err_o  = w_timeout;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign gnt_o    = {r_state == OWN1, r_state == OWN0};

`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] r_wd;
  logic       w_mstb;
  logic       w_stall;

  assign w_mstb    = (r_state == OWN0) ? m0_stb_i :
                     (r_state == OWN1) ? m1_stb_i : 1'b0;
  assign w_stall   = w_mstb & ~s_ack_i;
  assign w_timeout = w_stall && (r_wd == TO_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || !w_stall || w_timeout)
      r_wd <= '0;
    else
      r_wd <= r_wd + 8'd1;
  end
`else
  logic w_unused_timeout;
  assign w_timeout        = 1'b0;
  assign w_unused_timeout = ^TO_LAST;
`endif

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Bench for wb_ram_arbiter: one round-robin and one fixed-priority instance,
// each against a RAM, checked every cycle against a transaction-level model.
module tb_wb_ram_arbiter;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // [instance][master]
  logic [31:0] adr [2][2];
  logic [31:0] wdat[2][2];
  logic [3:0]  sel [2][2];
  logic        we  [2][2];
  logic        cyc [2][2];
  logic        stb [2][2];
  logic        ack [2][2];
  logic        err [2][2];
  logic [31:0] mdat[2][2];
  logic        instr0[2];

  logic [31:0] s_adr[2], s_wdat[2], s_rdat[2];
  logic [3:0]  s_sel[2];
  logic        s_we[2], s_cyc[2], s_stb[2], s_instr[2], s_ack[2];
  logic [1:0]  gnt[2];

  logic [31:0] ram [2][16];
  logic [31:0] refm[2][16];

  // Model state: owner 0 = nobody, 1 = master 0, 2 = master 1.
  int own[2], last[2], wdc[2];
  bit acked[2][2];

  int checks = 0;
  int errors = 0;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    wb_ram_arbiter #(.PRIO_FIXED(k), .TIMEOUT(TO)) u_dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .m0_adr_i(adr[k][0]), .m0_dat_i(wdat[k][0]), .m0_sel_i(sel[k][0]),
      .m0_we_i(we[k][0]), .m0_cyc_i(cyc[k][0]), .m0_stb_i(stb[k][0]),
      .m0_instr_i(instr0[k]), .m0_ack_o(ack[k][0]), .m0_err_o(err[k][0]),
      .m0_dat_o(mdat[k][0]),
      .m1_adr_i(adr[k][1]), .m1_dat_i(wdat[k][1]), .m1_sel_i(sel[k][1]),
      .m1_we_i(we[k][1]), .m1_cyc_i(cyc[k][1]), .m1_stb_i(stb[k][1]),
      .m1_ack_o(ack[k][1]), .m1_err_o(err[k][1]), .m1_dat_o(mdat[k][1]),
      .s_adr_o(s_adr[k]), .s_dat_o(s_wdat[k]), .s_sel_o(s_sel[k]),
      .s_we_o(s_we[k]), .s_cyc_o(s_cyc[k]), .s_stb_o(s_stb[k]),
      .s_instr_o(s_instr[k]), .s_ack_i(s_ack[k]), .s_dat_i(s_rdat[k]),
      .gnt_o(gnt[k])
    );
    assign s_rdat[k] = ram[k][s_adr[k][5:2]];
  end

  task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[inst%0d] t=%0t got=%h expected=%h", nm, k, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // Check one cycle against the model, then advance model and memories across the edge.
  task automatic tick();
    int o, nown[2], nlast[2], nwd[2];
    bit to;
    bit dw[2], rw[2];
    logic [31:0] da[2], dd[2], ra[2], rd[2];
    logic [3:0]  ds[2], rs[2];
    #1;
    for (int k = 0; k < 2; k++) begin
      o  = own[k];
      to = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
      to = (o != 0) && stb[k][o-1] && !s_ack[k] && (wdc[k] == TO - 1);
`endif
      chk(k, "gnt", {30'd0, gnt[k]}, (o == 1) ? 32'd1 : (o == 2) ? 32'd2 : 32'd0);
      chk(k, "s_cyc", {31'd0, s_cyc[k]}, (o != 0) ? {31'd0, cyc[k][o-1]} : 32'd0);
      chk(k, "s_stb", {31'd0, s_stb[k]}, (o != 0) ? {31'd0, stb[k][o-1] & !to} : 32'd0);
      chk(k, "s_instr", {31'd0, s_instr[k]}, (o == 1) ? {31'd0, instr0[k]} : 32'd0);
      for (int m = 0; m < 2; m++) begin
        chk(k, m ? "m1_ack" : "m0_ack", {31'd0, ack[k][m]}, {31'd0, (o == m + 1) && s_ack[k]});
        chk(k, m ? "m1_err" : "m0_err", {31'd0, err[k][m]}, {31'd0, (o == m + 1) && to});
        if (o == m + 1 && s_ack[k] && !we[k][m])
          chk(k, m ? "m1_dat" : "m0_dat", mdat[k][m], refm[k][adr[k][m][5:2]]);
        acked[k][m] = (o == m + 1) && s_ack[k];
      end
      if (o != 0) begin
        chk(k, "s_adr", s_adr[k], adr[k][o-1]);
        chk(k, "s_dat", s_wdat[k], wdat[k][o-1]);
        chk(k, "s_sel", {28'd0, s_sel[k]}, {28'd0, sel[k][o-1]});
        chk(k, "s_we", {31'd0, s_we[k]}, {31'd0, we[k][o-1]});
      end else begin
        chk(k, "s_we", {31'd0, s_we[k]}, 32'd0);
      end
      dw[k] = s_ack[k] && s_cyc[k] && s_we[k];
      da[k] = s_adr[k]; dd[k] = s_wdat[k]; ds[k] = s_sel[k];
      rw[k] = (o != 0) && s_ack[k] && we[k][o-1];
      if (o != 0) begin
        ra[k] = adr[k][o-1]; rd[k] = wdat[k][o-1]; rs[k] = sel[k][o-1];
      end
      if (rst) begin
        nown[k] = 0; nlast[k] = 1; nwd[k] = 0;
      end else begin
        nown[k] = o; nlast[k] = last[k];
        if (o == 0) begin
          if (cyc[k][0] && cyc[k][1]) nown[k] = (k == 1 || last[k] == 1) ? 1 : 2;
          else if (cyc[k][0]) nown[k] = 1;
          else if (cyc[k][1]) nown[k] = 2;
        end else if (!cyc[k][o-1]) begin
          nown[k] = 0; nlast[k] = o - 1;
        end
        nwd[k] = (o != 0 && stb[k][o-1] && !s_ack[k] && !to) ? wdc[k] + 1 : 0;
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      own[k] = nown[k]; last[k] = nlast[k]; wdc[k] = nwd[k];
      if (dw[k]) ram[k][da[k][5:2]] = merge(ram[k][da[k][5:2]], dd[k], ds[k]);
      if (rw[k]) refm[k][ra[k][5:2]] = merge(refm[k][ra[k][5:2]], rd[k], rs[k]);
    end
    @(negedge clk);
  endtask

  task automatic set_req(input int k, input int m, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    cyc[k][m] = 1'b1; stb[k][m] = 1'b1; we[k][m] = w;
    adr[k][m] = a; wdat[k][m] = d; sel[k][m] = s;
  endtask

  task automatic drop_all();
    for (int k = 0; k < 2; k++) begin
      for (int m = 0; m < 2; m++) begin
        cyc[k][m] = 1'b0; stb[k][m] = 1'b0;
      end
      s_ack[k] = 1'b0;
    end
  endtask

  task automatic new_xfer(input int k, input int m);
    logic [3:0] a;
    a = 4'($urandom_range(0, 15));
    set_req(k, m, 1'($urandom_range(0, 1)), {26'd0, a, 2'b00}, $urandom, 4'($urandom_range(1, 15)));
    if (m == 0) instr0[k] = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_random();
    for (int k = 0; k < 2; k++) begin
      for (int m = 0; m < 2; m++) begin
        if (!cyc[k][m]) begin
          if ($urandom_range(0, 2) != 0) new_xfer(k, m);
        end else if (acked[k][m]) begin
          case ($urandom_range(0, 3))
            0: new_xfer(k, m);
            1: stb[k][m] = 1'b0;
            default: begin cyc[k][m] = 1'b0; stb[k][m] = 1'b0; end
          endcase
        end else if (!stb[k][m]) begin
          new_xfer(k, m);
        end
      end
      s_ack[k] = (own[k] != 0) && stb[k][own[k]-1] && ($urandom_range(0, 2) != 0);
    end
    rst = ($urandom_range(0, 299) == 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      own[k] = 0; last[k] = 1; wdc[k] = 0; instr0[k] = 1'b0; s_ack[k] = 1'b0;
      for (int m = 0; m < 2; m++) begin
        adr[k][m] = '0; wdat[k][m] = '0; sel[k][m] = '0; we[k][m] = 1'b0;
        cyc[k][m] = 1'b0; stb[k][m] = 1'b0; acked[k][m] = 1'b0;
      end
      for (int i = 0; i < 16; i++) begin
        ram[k][i] = 32'h0100_0000 * i + 32'h0000_0011 * i;
        refm[k][i] = ram[k][i];
      end
      ram[k][4] = 32'h1234_5678;  refm[k][4] = 32'h1234_5678;
      ram[k][8] = 32'hAAAA_5555;  refm[k][8] = 32'hAAAA_5555;
    end
    @(negedge clk);
    tick(); tick();
    rst = 1'b0;

    // Single read by master 0 at 0x10.
    for (int k = 0; k < 2; k++) set_req(k, 0, 1'b0, 32'h10, 32'h0, 4'hF);
    tick();
    for (int k = 0; k < 2; k++) s_ack[k] = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk(k, "t1_gnt", {30'd0, gnt[k]}, 32'd1);
      chk(k, "t1_dat", mdat[k][0], 32'h1234_5678);
      chk(k, "t1_m1ack", {31'd0, ack[k][1]}, 32'd0);
    end
    tick();
    drop_all();
    tick(); tick();

    // Simultaneous requests, four rounds from reset.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 2; k++) begin
        set_req(k, 0, 1'b0, 32'(r * 4), 32'h0, 4'hF);
        set_req(k, 1, 1'b0, 32'(r * 4 + 32), 32'h0, 4'hF);
      end
      #1;
      for (int k = 0; k < 2; k++) chk(k, "t2_idle", {30'd0, gnt[k]}, 32'd0);
      tick();
      for (int k = 0; k < 2; k++) s_ack[k] = 1'b1;
      #1;
      chk(0, "t2_rr_gnt", {30'd0, gnt[0]}, (r % 2 == 0) ? 32'd1 : 32'd2);
      chk(1, "t3_fix_gnt", {30'd0, gnt[1]}, 32'd1);
      tick();
      drop_all();
      tick();
    end

    // Master 1 partial write while master 0 waits.
    for (int k = 0; k < 2; k++) set_req(k, 1, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'b0011);
    tick();
    for (int k = 0; k < 2; k++) set_req(k, 0, 1'b0, 32'h0, 32'h0, 4'hF);
    #1;
    for (int k = 0; k < 2; k++) chk(k, "t4_stall_ack", {31'd0, ack[k][0]}, 32'd0);
    tick();
    for (int k = 0; k < 2; k++) s_ack[k] = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) chk(k, "t4_m0ack_own1", {31'd0, ack[k][0]}, 32'd0);
    tick();
    for (int k = 0; k < 2; k++) begin
      cyc[k][1] = 1'b0; stb[k][1] = 1'b0; s_ack[k] = 1'b0;
    end
    tick(); tick();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk(k, "t4_gnt_m0", {30'd0, gnt[k]}, 32'd1);
      chk(k, "t4_ram8", ram[k][8], 32'hAAAA_BEEF);
    end
    for (int k = 0; k < 2; k++) s_ack[k] = 1'b1;
    tick();
    drop_all();
    tick(); tick();

`ifdef WB_ARB_TIMEOUT_EN
    // Watchdog with a slave that never acks.
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 2; k++) set_req(k, 0, 1'b0, 32'h8, 32'h0, 4'hF);
    tick();
    for (int i = 0; i < TO; i++) begin
      #1;
      for (int k = 0; k < 2; k++) chk(k, "t5_err", {31'd0, err[k][0]}, (i == TO - 1) ? 32'd1 : 32'd0);
      tick();
    end
    drop_all();
    tick(); tick();
`endif

    // Reset in the middle of a master 1 burst.
    for (int k = 0; k < 2; k++) set_req(k, 1, 1'b0, 32'h4, 32'h0, 4'hF);
    tick();
    for (int k = 0; k < 2; k++) s_ack[k] = 1'b1;
    tick();
    for (int k = 0; k < 2; k++) adr[k][1] = 32'h8;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk(k, "t6_gnt", {30'd0, gnt[k]}, 32'd0);
      chk(k, "t6_cyc", {31'd0, s_cyc[k]}, 32'd0);
      chk(k, "t6_stb", {31'd0, s_stb[k]}, 32'd0);
      chk(k, "t6_acks", {30'd0, ack[k][1], ack[k][0]}, 32'd0);
      chk(k, "t6_errs", {30'd0, err[k][1], err[k][0]}, 32'd0);
    end
    tick();
    drop_all();
    tick(); tick();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      drive_random();
      tick();
    end
    rst = 1'b0;
    drop_all();
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
